// File: rtl/iob_native_mem_resp_pkg.sv
// Shared types and constants for the native memory responder: FSM encoding,
// latency counter width and the stall LFSR polynomial.
package iob_native_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int LFSR_W = 8;
  // Taps 8,6,5,4 of the Fibonacci polynomial map to state bits 7,5,4,3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/iob_native_mem_resp_if.sv
// Native memory request/response bus. Handshake: the master raises valid with
// addr/wdata/wstrb and holds it until ready; ready is a single-cycle completion pulse.
interface iob_native_mem_resp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_native_mem_resp_lfsr.sv
// 8-bit Fibonacci LFSR used to generate pseudo-random stall cycles.
module iob_lfsr8
  import iob_native_mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  input  logic              enable,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= seed;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/iob_native_mem_resp.sv
// Native memory responder: byte-writable word array answering after LATENCY cycles.
// Define MEM_RESP_RAND_STALL_EN to add 0..3 pseudo-random stall cycles per request.
module iob_native_mem_resp
  import iob_native_mem_resp_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 14,
  parameter int          LATENCY   = 1,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  iob_native_mem_resp_if.slave  bus,
  output logic [31:0]           n_reads,
  output logic [31:0]           n_writes,
  output state_t                state
);

  localparam int NB      = DATA_W / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam int WADDR_W = ADDR_W - OFF_W;
  localparam int DEPTH   = 2 ** WADDR_W;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_err
    $error("iob_native_mem_resp: LATENCY must be in 1..15");
  end
  if (DATA_W % 8 != 0) begin : g_dw_err
    $error("iob_native_mem_resp: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [WADDR_W-1:0] word_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [NB-1:0]      wstrb_q;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         stall;
  logic               ready_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [WADDR_W-1:0] word_in;
  logic [CNT_W-1:0]   load_cnt;

`ifdef MEM_RESP_RAND_STALL_EN
  if (LATENCY > 13) begin : g_stall_err
    $error("iob_native_mem_resp: LATENCY+3 stall must fit the latency counter");
  end
  logic [LFSR_W-1:0] lfsr;
  logic              unused_lfsr_bits;
  iob_lfsr8 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .seed   (LFSR_SEED),
    .enable (1'b1),
    .state  (lfsr)
  );
  assign stall = lfsr[1:0];
  assign unused_lfsr_bits = ^lfsr[LFSR_W-1:2];
`else
  assign stall = 2'd0;
`endif

  // Sub-word address bits select nothing; the array is word addressed.
  assign word_in = bus.addr[ADDR_W-1:OFF_W];
  if (OFF_W > 0) begin : g_unused_off
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[OFF_W-1:0];
  end

  assign load_cnt  = CNT_W'(LATENCY - 1) + CNT_W'(stall);
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      n_reads  <= '0;
      n_writes <= '0;
      cnt      <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      case (state)
        IDLE: begin
          if (bus.valid) begin
            word_q  <= word_in;
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
            cnt     <= load_cnt;
            if (load_cnt == '0) begin
              state   <= RESP;
              ready_q <= 1'b1;
              rdata_q <= (|bus.wstrb) ? '0 : mem[word_in];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= RESP;
            ready_q <= 1'b1;
            rdata_q <= (|wstrb_q) ? '0 : mem[word_q];
          end
        end
        RESP: begin
          state <= IDLE;
          if (|wstrb_q) n_writes <= n_writes + 32'd1;
          else          n_reads  <= n_reads + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write lands on the edge that ends RESP, so a reset during RESP drops it.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_q[b]) mem[word_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule
